// File: rtl/time_display_scan_if.sv
// time_display_scan_if: time fields, display controls and scan outputs of the display block
interface time_display_scan_if;
    logic [15:0] year;
    logic [5:0]  month;
    logic [10:0] day;
    logic [10:0] hour;
    logic [10:0] minute;
    logic [10:0] second;
    logic        mode;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        frame_start;
    modport master (
        output year, month, day, hour, minute, second, mode, blink_mask,
        input  an, seg, dp, busy, frame_start
    );
    modport slave (
        input  year, month, day, hour, minute, second, mode, blink_mask,
        output an, seg, dp, busy, frame_start
    );
endinterface

// File: rtl/time_display_scan.sv
// time_display_scan: snapshots time fields, converts them to BCD and scans an 8-digit 7-segment display
module time_display_scan #(
    parameter int DIV          = 16,
    parameter int BLINK_FRAMES = 32
) (
    input logic                clk,
    input logic                rst,
    time_display_scan_if.slave bus
);
    localparam int DW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    typedef enum logic [2:0] {IDLE, SNAP, LOAD, SHIFT, COMMIT} state_t;
    state_t        state, state_n;
    logic [DW-1:0] div_cnt;
    logic [2:0]    dig_idx;
    logic [FW-1:0] frame_cnt;
    logic          phase, pending, mode_s, fs_r, blank;
    logic [7:0]    an_r;
    logic [6:0]    seg_r, seg_on;
    logic [15:0]   snap [8];
    logic [15:0]   work [8];
    logic [3:0]    disp [8];
    logic [15:0]   sh, bcd, adj;
    logic [3:0]    bit_cnt, code;
    logic [2:0]    fld;

    function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign bus.an          = an_r;
    assign bus.seg         = seg_r;
    assign bus.dp          = 1'b1;
    assign bus.busy        = (state != IDLE);
    assign bus.frame_start = fs_r;

    // Digit decode for the current slot and the add-3 step of double dabble
    always_comb begin
        code   = disp[dig_idx];
        blank  = (code == 4'd15) || (bus.blink_mask[dig_idx] && phase);
        seg_on = (code == 4'd0)  ? 7'h3F :
                 (code == 4'd1)  ? 7'h06 :
                 (code == 4'd2)  ? 7'h5B :
                 (code == 4'd3)  ? 7'h4F :
                 (code == 4'd4)  ? 7'h66 :
                 (code == 4'd5)  ? 7'h6D :
                 (code == 4'd6)  ? 7'h7D :
                 (code == 4'd7)  ? 7'h07 :
                 (code == 4'd8)  ? 7'h7F :
                 (code == 4'd9)  ? 7'h6F :
                 (code == 4'd10) ? 7'h40 : 7'h00;
        adj = bcd;
        for (int k = 0; k < 4; k++)
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    // Digit scan timing, blink phase and registered display pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            dig_idx   <= '0;
            fs_r      <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b0;
            an_r      <= 8'hFF;
            seg_r     <= 7'h7F;
        end else begin
            div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DW'(DIV - 1))
                dig_idx <= dig_idx + 1'b1;
            fs_r <= (div_cnt == DW'(DIV - 1)) && (dig_idx == 3'd7);
            if (fs_r) begin
                frame_cnt <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
                if (frame_cnt == FW'(BLINK_FRAMES - 1))
                    phase <= ~phase;
            end
            an_r  <= ~(8'd1 << dig_idx);
            seg_r <= blank ? 7'h7F : ~seg_on;
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Conversion FSM next state: one LOAD plus 16 SHIFTs per field, six fields
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (fs_r || pending) ? SNAP : IDLE;
            SNAP:    state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   state_n = (bit_cnt != 4'd15) ? SHIFT : (fld == 3'd5) ? COMMIT : LOAD;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Conversion datapath: snapshot, shift-and-add-3, working bank, display bank commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b1;
            mode_s  <= 1'b0;
            sh      <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            fld     <= '0;
            for (int k = 0; k < 8; k++) begin
                snap[k] <= '0;
                work[k] <= 16'hFFFF;
                disp[k] <= 4'hF;
            end
        end else begin
            pending <= (state == IDLE) ? 1'b0 : (pending | fs_r);
            case (state)
                SNAP: begin
                    snap[0] <= clamp(bus.year, 16'd9999);
                    snap[1] <= clamp({10'd0, bus.month}, 16'd99);
                    snap[2] <= clamp({5'd0, bus.day}, 16'd99);
                    snap[3] <= clamp({5'd0, bus.hour}, 16'd99);
                    snap[4] <= clamp({5'd0, bus.minute}, 16'd99);
                    snap[5] <= clamp({5'd0, bus.second}, 16'd99);
                    mode_s  <= bus.mode;
                    fld     <= '0;
                end
                LOAD: begin
                    sh      <= snap[fld];
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    sh      <= sh << 1;
                    bcd     <= {adj[14:0], sh[15]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'd15) begin
                        work[fld] <= {adj[14:0], sh[15]};
                        fld       <= fld + 1'b1;
                    end
                end
                COMMIT: begin
                    disp[7] <= mode_s ? work[0][15:12] : work[3][7:4];
                    disp[6] <= mode_s ? work[0][11:8]  : work[3][3:0];
                    disp[5] <= mode_s ? work[0][7:4]   : 4'd10;
                    disp[4] <= mode_s ? work[0][3:0]   : work[4][7:4];
                    disp[3] <= mode_s ? work[1][7:4]   : work[4][3:0];
                    disp[2] <= mode_s ? work[1][3:0]   : 4'd10;
                    disp[1] <= mode_s ? work[2][7:4]   : work[5][7:4];
                    disp[0] <= mode_s ? work[2][3:0]   : work[5][3:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: directed scoreboard bench for the time/date display scanner
module tb_time_display_scan;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fs_n;
    int   yr, mo, dy, hr, mi, sc;
    logic md;
    logic [6:0] exp_q [$];
    logic [6:0] tbl [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                             7'b0111111};

    always #5 clk = ~clk;

    time_display_scan_if bus();

    time_display_scan #(.DIV(16), .BLINK_FRAMES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Independent count of frame starts since reset, used for the blink phase model
    always @(posedge clk or posedge rst)
        if (rst) fs_n <= 0;
        else if (bus.frame_start) fs_n <= fs_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic apply();
        bus.year   = yr[15:0];
        bus.month  = mo[5:0];
        bus.day    = dy[10:0];
        bus.hour   = hr[10:0];
        bus.minute = mi[10:0];
        bus.second = sc[10:0];
        bus.mode   = md;
    endtask

    function automatic logic [31:0] layout();
        int y  = (yr > 9999) ? 9999 : yr;
        int m  = (mo > 99) ? 99 : mo;
        int d  = (dy > 99) ? 99 : dy;
        int h  = (hr > 99) ? 99 : hr;
        int n  = (mi > 99) ? 99 : mi;
        int s  = (sc > 99) ? 99 : sc;
        if (md)
            return {4'(y / 1000), 4'(y / 100 % 10), 4'(y / 10 % 10), 4'(y % 10),
                    4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
        return {4'(h / 10), 4'(h % 10), 4'd10, 4'(n / 10), 4'(n % 10), 4'd10, 4'(s / 10), 4'(s % 10)};
    endfunction

    // Slot 7 is seen in frame n, slots 0..6 early in frame n+1
    task automatic push_frame(input logic [31:0] codes, input int n);
        for (int k = 0; k < 8; k++) begin
            int s = (k == 0) ? 7 : k - 1;
            logic [3:0] c = codes[4*s +: 4];
            int ph = (s == 7) ? (n / 2) % 2 : ((n + 1) / 2) % 2;
            exp_q.push_back((c == 4'd15 || (bus.blink_mask[s] && ph == 1)) ? 7'h7F : tbl[c]);
        end
    endtask

    task automatic scan(input string tag);
        for (int k = 0; k < 8; k++) begin
            int s = (k == 0) ? 7 : k - 1;
            logic found = 1'b0;
            for (int c = 0; c < 300 && !found; c++) begin
                @(negedge clk);
                found = (bus.an === ~(8'd1 << s));
            end
            check($sformatf("%s_an%0d", tag, s), found, 1);
            repeat (3) @(negedge clk);
            if (exp_q.size() > 0) check($sformatf("%s_seg%0d", tag, s), bus.seg, exp_q.pop_front());
        end
    endtask

    task automatic wait_fs();
        logic found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            found = bus.frame_start;
        end
        check("fs_seen", found, 1);
        @(posedge clk);
        #1;
        check("fs_pulse", bus.frame_start, 0);
        check("busy_snap", bus.busy, 1);
    endtask

    task automatic wait_idle();
        logic idle = 1'b0;
        for (int c = 0; c < 300 && !idle; c++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        check("idle", idle, 1);
    endtask

    task automatic latency(input string tag);
        int cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
            else if (cnt > 0) break;
        end
        check(tag, cnt, 104);
    endtask

    task automatic frame(input string tag);
        wait_fs();
        push_frame(layout(), fs_n);
        wait_idle();
        scan(tag);
    endtask

    initial begin
        yr = 2023; mo = 5; dy = 9; hr = 12; mi = 34; sc = 56; md = 1'b0;
        bus.blink_mask = 8'h00;
        apply();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 8'hFF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp", bus.dp, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_fs", bus.frame_start, 0);
        rst = 1'b0;
        latency("lat_first");
        push_frame(layout(), fs_n);
        scan("time");
        md = 1'b1; apply();
        frame("date");
        hr = 1500; yr = 12345; apply();
        frame("clamp_date");
        md = 1'b0; apply();
        frame("clamp_time");
        hr = 12; yr = 2023; sc = 59; apply();
        frame("sec59");
        wait_fs();
        push_frame(layout(), fs_n);
        repeat (3) @(negedge clk);
        sc = 0; apply();
        wait_idle();
        scan("sec_hold");
        frame("sec0");
        bus.blink_mask = 8'h03;
        frame("blink_a");
        frame("blink_b");
        frame("blink_c");
        md = 1'b1; yr = 1999; mo = 12; dy = 31; apply();
        wait_fs();
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_an", bus.an, 8'hFF);
        check("async_seg", bus.seg, 7'h7F);
        check("async_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        latency("lat_rst");
        push_frame(layout(), fs_n);
        scan("post_rst");
        check("dp_hold", bus.dp, 1);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
